md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Sequencer for the shared multiply/divide resource in the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Raises a stall request for the hazard unit while a D-stage HI/LO instruction must wait.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- IR_D  input  32  instruction in D stage.
- IR_E  input  32  instruction in E stage; a bubble is all-zero.
- A_E  input  32  forwarded rs value in E.
- B_E  input  32  forwarded rt value in E.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MD_out  output  32  HI for mfhi in E, LO for mflo in E, else 0.
- Busy  output  1  operation in progress.
- Start  output  1  combinational; a mult/multu/div/divu is in E this cycle.
- MD_stall  output  1  combinational stall request, ORed into the pipeline Stop.

Behaviour:
- Decode uses opcode 000000 with these funct codes:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
- md_D is any of these eight ops in IR_D.
- Start = IR_E is mult/multu/div/divu.
- MD_stall = md_D & (Start | Busy).
  - The hazard unit therefore never lets a second HI/LO op reach E while the unit is occupied.
- States: IDLE and BUSY; Busy = (state == BUSY).
- IDLE with Start at edge t:
  - Latch the computed result into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY, each edge:
  - If cnt > 1, decrement cnt.
  - If cnt == 1, copy pend_hi/pend_lo into HI/LO, set cnt = 0, go to IDLE.
- Busy is high exactly N cycles after the Start edge.
  - New HI/LO values are visible in the first cycle Busy is low.
- Start while BUSY cannot occur (prevented by the stall).
  - If it does occur anyway, it is ignored and no state changes.
- mthi/mtlo in E (IDLE only) write HI or LO from A_E at the edge; single cycle, Busy unaffected.
- mfhi/mflo in E drive MD_out combinationally from the current HI/LO.
- Arithmetic:
  - mult: signed 32x32 -> 64, {HI,LO} = product.
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: same, unsigned.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero:
  - Busy still runs DIV_CYCLES.
  - HI/LO keep their previous values; pend registers are not loaded.
- Reset (asynchronous, any time, including mid-operation):
  - HI = LO = 0, pend = 0, cnt = 0, state = IDLE, Busy = 0.
  - The in-flight result is discarded.

Decomposition:
- Shared package md_defs holds:
  - the funct constants above and the R-type opcode;
  - state encodings IDLE/BUSY;
  - default cycle counts.
  - The hazard unit reuses the same funct constants.
- One natural combinational sub-module, md_alu:
  - inputs: op, A_E, B_E;
  - outputs: 64-bit result and a div-by-zero flag.
  - This keeps the sequencer purely control plus registers.

Test Plan:
- Reset low mid-mult (Busy=1, cnt=3) -> HI=LO=0 and Busy=0 immediately; after release, mfhi in E gives MD_out=0.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=LO=5 -> HI/LO stay 5.
- mflo in D while Start=1, then for all Busy cycles -> MD_stall=1 each cycle; it drops with Busy, and the next mflo in E gives MD_out = new LO.
- mthi A=0x12345678 in E, then mfhi in the following E cycle -> MD_out=0x12345678; MD_stall=0 throughout.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Back-to-back mult/mult with the stall honoured -> the second Start arrives only after Busy falls, and the final HI/LO reflect the second product.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// md_defs: multiply/divide opcodes, funct codes, op and state encodings, default latencies, decode helpers
package md_defs;
  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_e;
  typedef enum logic {IDLE, BUSY} md_state_e;
  function automatic logic is_fn(input logic [31:0] ir, input logic [5:0] f);
    return ir[31:26] == OPC_R && ir[5:0] == f;
  endfunction
  function automatic logic is_md(input logic [31:0] ir);
    return ir[31:26] == OPC_R && ir[5:4] == 2'b01 && !ir[2];
  endfunction
endpackage

// File: rtl/md_ctrl_alu.sv
// md_alu: combinational mult/multu/div/divu; ports op, a, b in; res {hi,lo} and dz (divisor zero) out
module md_alu
  import md_defs::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        dz
);
  logic signed [63:0] ps;
  logic [63:0] pu;
  logic [31:0] bd, qs, rs, qu, ru;
  logic ovf;
  assign ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign pu  = {32'b0, a} * {32'b0, b};
  assign dz  = b == 32'b0;
  assign ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign bd  = (dz || ovf) ? 32'd1 : b;
  assign qs  = $signed(a) / $signed(bd);
  assign rs  = $signed(a) % $signed(bd);
  assign qu  = a / bd;
  assign ru  = a % bd;
  always_comb res = op == OP_MULT  ? ps :
                    op == OP_MULTU ? pu :
                    op == OP_DIV   ? {rs, qs} : {ru, qu};
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO sequencer; in clk, reset(n), IR_D, IR_E, A_E, B_E; out HI, LO, MD_out, Busy, Start, MD_stall
module md_ctrl
  import md_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out,
  output logic        Busy,
  output logic        Start,
  output logic        MD_stall
);
  md_state_e state, state_d;
  logic [3:0] cnt;
  logic [63:0] pend, res;
  logic dz, skip, dz_div;
  logic unused;
  md_alu u_alu (.op(md_op_e'(IR_E[1:0])), .a(A_E), .b(B_E), .res(res), .dz(dz));
  assign unused   = ^{IR_D[25:6], IR_E[25:6]};
  assign Start    = IR_E[31:26] == OPC_R && IR_E[5:2] == 4'b0110;
  assign dz_div   = IR_E[1] && dz;
  assign Busy     = state == BUSY;
  assign MD_stall = is_md(IR_D) && (Start || Busy);
  assign MD_out   = is_fn(IR_E, F_MFHI) ? HI : is_fn(IR_E, F_MFLO) ? LO : 32'b0;
  always_comb state_d = state == IDLE ? (Start ? BUSY : IDLE) : (cnt > 4'd1 ? BUSY : IDLE);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      skip  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE) begin
        if (Start) begin
          cnt  <= IR_E[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          skip <= dz_div;
          if (!dz_div) pend <= res;
        end else begin
          if (is_fn(IR_E, F_MTHI)) HI <= A_E;
          if (is_fn(IR_E, F_MTLO)) LO <= A_E;
        end
      end else if (cnt > 4'd1) begin
        cnt <= cnt - 4'd1;
      end else begin
        cnt <= '0;
        if (!skip) {HI, LO} <= pend;
      end
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl driving directed HI/LO instruction sequences
module tb_md_ctrl;
  import md_defs::*;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;
  localparam int S_HI = 0, S_LO = 1, S_OUT = 2, S_BUSY = 3, S_STALL = 4, S_START = 5;
  logic clk = 0, reset = 0;
  logic [31:0] IR_D = 0, IR_E = 0, A_E = 0, B_E = 0;
  logic [31:0] HI, LO, MD_out;
  logic Busy, Start, MD_stall;
  exp_t q[$];
  int checks = 0, errors = 0;
  md_ctrl dut (.clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .A_E(A_E), .B_E(B_E),
               .HI(HI), .LO(LO), .MD_out(MD_out), .Busy(Busy), .Start(Start), .MD_stall(MD_stall));
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [5:0] f);
    return {OPC_R, 20'b0, f};
  endfunction
  function automatic logic [31:0] pick(input int sel);
    return sel == S_HI ? HI : sel == S_LO ? LO : sel == S_OUT ? MD_out :
           sel == S_BUSY ? {31'b0, Busy} : sel == S_STALL ? {31'b0, MD_stall} : {31'b0, Start};
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h at %0t", e.name, act, e.val, $time);
      end
    end
  end
  task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    IR_D = d; IR_E = e; A_E = a; B_E = b;
  endtask
  task automatic expect_v(input string n, input int sel, input logic [31:0] v);
    q.push_back('{n, sel, v});
  endtask
  task automatic run_op(input string n, input logic [31:0] d, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input int cyc,
                        input logic stall, input logic [31:0] hi, input logic [31:0] lo);
    step(d, ins(f), a, b);
    expect_v({n, " start"}, S_START, 1);
    expect_v({n, " start busy"}, S_BUSY, 0);
    expect_v({n, " start stall"}, S_STALL, {31'b0, stall});
    for (int i = 0; i < cyc; i++) begin
      step(d, 0, 0, 0);
      expect_v({n, " busy"}, S_BUSY, 1);
      expect_v({n, " busy stall"}, S_STALL, {31'b0, stall});
    end
    step(0, 0, 0, 0);
    expect_v({n, " done busy"}, S_BUSY, 0);
    expect_v({n, " hi"}, S_HI, hi);
    expect_v({n, " lo"}, S_LO, lo);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1;
    step(0, 0, 0, 0);
    expect_v("reset hi", S_HI, 0);
    expect_v("reset lo", S_LO, 0);
    expect_v("reset busy", S_BUSY, 0);
    run_op("mult", 0, F_MULT, 32'hFFFF_FFFE, 3, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 0, F_MULTU, 32'hFFFF_FFFE, 3, 5, 0, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div", 0, F_DIV, 32'hFFFF_FFF9, 2, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step(0, ins(F_MTHI), 5, 0);
    step(0, ins(F_MTLO), 5, 0);
    run_op("divu0", 0, F_DIVU, 7, 0, 10, 0, 5, 5);
    run_op("stall", ins(F_MFLO), F_MULT, 6, 7, 5, 1, 0, 42);
    expect_v("stall drop", S_STALL, 0);
    step(0, ins(F_MFLO), 0, 0);
    expect_v("mflo new lo", S_OUT, 42);
    step(ins(F_MFHI), ins(F_MTHI), 32'h1234_5678, 0);
    expect_v("mthi stall", S_STALL, 0);
    step(0, ins(F_MFHI), 0, 0);
    expect_v("mfhi after mthi", S_OUT, 32'h1234_5678);
    expect_v("mfhi stall", S_STALL, 0);
    run_op("div ovf", 0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 0, 32'h8000_0000);
    run_op("b2b first", ins(F_MULT), F_MULT, 3, 4, 5, 1, 0, 12);
    run_op("b2b second", 0, F_MULT, 32'h0001_0000, 32'h0001_0000, 5, 0, 1, 0);
    step(0, ins(F_MULT), 32'h0000_1111, 32'h0000_2222);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_v("pre-reset busy", S_BUSY, 1);
    step(0, 0, 0, 0);
    reset = 0;
    expect_v("async reset busy", S_BUSY, 0);
    expect_v("async reset hi", S_HI, 0);
    expect_v("async reset lo", S_LO, 0);
    step(0, 0, 0, 0);
    reset = 1;
    step(0, ins(F_MFHI), 0, 0);
    expect_v("post reset mfhi", S_OUT, 0);
    expect_v("post reset busy", S_BUSY, 0);
    step(0, 0, 0, 0);
    expect_v("post reset idle", S_BUSY, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
